quicksort_ctrl: RTL and testbench
=================================

// Module: quicksort_ctrl
// PURPOSE
//  Initiator/sequencer for the fixed-point quicksort partition engine: it owns a
//  segment stack and issues one partition request per segment (low index,
//  element count). It consumes the engine's done/pivot-index response and
//  pushes the resulting sub-segments until the whole array is sorted in place.
//  Sits between the memory-load logic and the partition engine; drives its
//  load strobe and start, and reads its done flag and pivot index.
// PARAMETERS
//  K    10     max elements in the array (matches the partition engine K)
//  IW   $clog2(K)+1  index/count width (matches engine H/No_element/index)
//  SD   K/2+1  segment stack depth; holds only disjoint segments >=2, never overflows
//  TMO  4*K*K  watchdog cycles allowed per partition in RUN
// PORTS
//  clk         in   1    system clock, rising edge
//  rst_n       in   1    async active-low reset
//  start       in   1    1-cycle request to sort; ignored while busy
//  n_total     in   IW   elements to sort (0..K), sampled with start
//  mem_load    out  1    1-cycle strobe to engine finish_mem (engine latches array)
//  part_start  out  1    level start_sort to engine
//  part_low    out  IW   segment low index to engine H
//  part_count  out  IW   segment element count to engine No_element
//  part_done   in   1    engine finish_sort
//  part_index  in   IW   engine final pivot index, valid when part_done=1
//  busy        out  1    high from cycle after start until sort_done
//  sort_done   out  1    1-cycle pulse, sort complete (or aborted on err)
//  err         out  1    sticky; bad pivot index, stack overflow, or watchdog
//  parts_cnt   out  IW   partitions completed in current sort
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, stack empty, every output 0.
//  - FSM: IDLE -> LOAD -> POP -> SETUP -> RUN -> SPLIT -> POP ... -> DONE -> IDLE.
//  - IDLE: start=1 latches n_total, clears err and parts_cnt, goes to LOAD.
//  - LOAD (1 cyc): mem_load=1; push (0,n_total) only if n_total>=2.
//  - POP: stack empty -> DONE; else pop top into lo/n regs -> SETUP.
//  - SETUP (1 cyc): part_start=0, part_low=lo, part_count=n stable. The engine
//    reinitialises its scan indices only while start is low.
//  - RUN: part_start=1, part_low/count held. First cycle with part_done=1:
//    capture p=part_index, parts_cnt++, -> SPLIT (part_start drops next cycle).
//  - Watchdog: TMO cycles in RUN without part_done -> err=1, -> DONE.
//  - Range check: p<lo or p>lo+n-1 -> err=1, -> DONE, no pushes.
//  - SPLIT (1 cyc): left=(lo, p-lo), right=(p+1, lo+n-1-p). Only counts >=2 are
//    pushed. Larger pushed first, so smaller pops first; equal sizes: right first.
//  - Arithmetic in IW+1 bits; no wrap on p-lo or lo+n-1-p.
//  - Two pushes in one cycle are allowed; push past SD -> err=1, -> DONE.
//  - DONE (1 cyc): sort_done=1, busy=0 next cycle, -> IDLE. err holds.
//  - part_start is never high in IDLE/LOAD/POP/SETUP/SPLIT/DONE.
//  - start while busy is ignored. rst_n low mid-sort aborts with no sort_done.
// STRUCTURE
//  - Shared package qs_pkg: state enum, seg_t struct {low[IW], count[IW]}, IW
//    derivation, so the engine and the controller agree on widths.
//  - Sub-module qs_seg_stack: LIFO of seg_t, depth SD. Dual push (push_a then
//    push_b), single pop, empty/overflow flags, async reset.
//  - Controller FSM, watchdog counter and split arithmetic in this module.
// TESTING (bench uses a behavioural partition responder, K=10)
//  1 start, n_total=10, array 9..0 -> final array 0..9, sort_done once, err=0,
//    part_start low >=1 cycle between partitions with part_low stable.
//  2 start, n_total=1 -> mem_load at cycle 1, sort_done at cycle 3, no part_start.
//  3 sorted 0..9, responder returns p=lo -> segs (0,10),(1,9)..(8,2); parts_cnt=9,
//    stack occupancy never >1.
//  4 responder returns part_index=12 on first partition -> err=1, sort_done,
//    no pushes, next start clears err.
//  5 responder never asserts part_done -> err=1 and sort_done after TMO cycles in RUN.
//  6 rst_n low during RUN -> outputs 0 asynchronously; new start sorts 5..1 ok.

Source files
------------

// File: rtl/qs_pkg.sv
// Shared widths, state encoding and segment record for the quicksort controller.
// Keeps the controller and the partition engine agreed on index/count widths.
// No logic here; types and constants only.
package qs_pkg;

  localparam int K   = 10;
  localparam int IW  = $clog2(K) + 1;
  localparam int SD  = K / 2 + 1;
  localparam int TMO = 4 * K * K;
  localparam int WDW = $clog2(TMO);
  localparam int SPW = $clog2(SD + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_POP,
    ST_SETUP,
    ST_RUN,
    ST_SPLIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [IW-1:0] low;
    logic [IW-1:0] count;
  } seg_t;

endpackage

// File: rtl/qs_seg_stack.sv
// LIFO of pending segments: dual push per cycle (a lands below b), single pop.
// Top-of-stack is combinational; push/pop take effect on the next clock edge.
// A push that would exceed SD entries is refused and flagged on ovf.
module qs_seg_stack
  import qs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push_a,
  input  seg_t dat_a,
  input  logic push_b,
  input  seg_t dat_b,
  input  logic pop,
  output seg_t top,
  output logic empty,
  output logic ovf
);

  seg_t           mem [SD];
  logic [SPW-1:0] cnt;
  logic [SPW-1:0] top_idx;
  logic [SPW:0]   need;

  // Occupancy after the requested pushes, and the resulting overflow flag
  always_comb begin
    need    = {1'b0, cnt} + (SPW+1)'(push_a) + (SPW+1)'(push_b);
    ovf     = (need > (SPW+1)'(SD));
    empty   = (cnt == '0);
    top_idx = cnt - SPW'(1);
    top     = empty ? '0 : mem[top_idx];
  end

  // Storage and occupancy update; pop wins if both are requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < SD; i++) mem[i] <= '0;
    end else if (pop && !empty) begin
      cnt <= top_idx;
    end else if ((push_a || push_b) && !ovf) begin
      if (push_a) mem[cnt] <= dat_a;
      if (push_b) begin
        if (push_a) mem[cnt + SPW'(1)] <= dat_b;
        else        mem[cnt]           <= dat_b;
      end
      cnt <= need[SPW-1:0];
    end
  end

endmodule

// File: rtl/quicksort_ctrl.sv
// Sequencer for the partition engine: pops segments, runs one partition each, pushes sub-segments.
// Latency: load 1 cycle, then per segment POP+SETUP+RUN(engine time)+SPLIT; DONE pulse 1 cycle.
// Waits on the engine's done flag in RUN; a watchdog aborts after TMO cycles with err.
module quicksort_ctrl
  import qs_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [IW-1:0] n_total,
  output logic          mem_load,
  output logic          part_start,
  output logic [IW-1:0] part_low,
  output logic [IW-1:0] part_count,
  input  logic          part_done,
  input  logic [IW-1:0] part_index,
  output logic          busy,
  output logic          sort_done,
  output logic          err,
  output logic [IW-1:0] parts_cnt
);

  state_t         state, nstate;
  logic [IW-1:0]  ntot_q, lo_q, n_q, p_q, parts_q;
  logic [WDW-1:0] wd_q;
  logic           err_q;

  logic           push_a, push_b, pop, empty, ovf;
  seg_t           dat_a, dat_b, top;

  // Split arithmetic is one bit wider so p-lo and lo+n-1-p never wrap
  logic [IW:0]    lo_x, n_x, p_x, hi_x, idx_x, left_n, right_n;
  logic [IW-1:0]  right_lo;
  seg_t           left_seg, right_seg, big_seg, small_seg;
  logic           r_first, big_ok, small_ok, idx_bad, wd_exp;

  qs_seg_stack u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_a (push_a),
    .dat_a  (dat_a),
    .push_b (push_b),
    .dat_b  (dat_b),
    .pop    (pop),
    .top    (top),
    .empty  (empty),
    .ovf    (ovf)
  );

  // Segment bounds, pivot range check and larger-first ordering of the two halves
  always_comb begin
    lo_x      = {1'b0, lo_q};
    n_x       = {1'b0, n_q};
    p_x       = {1'b0, p_q};
    idx_x     = {1'b0, part_index};
    hi_x      = lo_x + n_x - (IW+1)'(1);
    idx_bad   = (idx_x < lo_x) || (idx_x > hi_x);
    left_n    = p_x - lo_x;
    right_n   = hi_x - p_x;
    right_lo  = p_q + IW'(1);
    left_seg.low    = lo_q;
    left_seg.count  = left_n[IW-1:0];
    right_seg.low   = right_lo;
    right_seg.count = right_n[IW-1:0];
    r_first   = (right_n >= left_n);
    big_seg   = r_first ? right_seg : left_seg;
    small_seg = r_first ? left_seg  : right_seg;
    big_ok    = r_first ? (right_n >= (IW+1)'(2)) : (left_n  >= (IW+1)'(2));
    small_ok  = r_first ? (left_n  >= (IW+1)'(2)) : (right_n >= (IW+1)'(2));
    wd_exp    = (wd_q == WDW'(TMO - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (start) nstate = ST_LOAD;
      ST_LOAD:  nstate = ST_POP;
      ST_POP:   nstate = empty ? ST_DONE : ST_SETUP;
      ST_SETUP: nstate = ST_RUN;
      ST_RUN: begin
        if (part_done)   nstate = idx_bad ? ST_DONE : ST_SPLIT;
        else if (wd_exp) nstate = ST_DONE;
      end
      ST_SPLIT: nstate = ovf ? ST_DONE : ST_POP;
      ST_DONE:  nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Moore outputs and stack requests decoded from the current state
  always_comb begin
    mem_load   = 1'b0;
    part_start = 1'b0;
    sort_done  = 1'b0;
    busy       = (state != ST_IDLE);
    pop        = 1'b0;
    push_a     = 1'b0;
    push_b     = 1'b0;
    dat_a      = '0;
    dat_b      = '0;
    case (state)
      ST_LOAD: begin
        mem_load    = 1'b1;
        push_a      = (ntot_q >= IW'(2));
        dat_a.count = ntot_q;
      end
      ST_POP:   pop = !empty;
      ST_RUN:   part_start = 1'b1;
      ST_SPLIT: begin
        push_a = big_ok;
        dat_a  = big_seg;
        push_b = small_ok;
        dat_b  = small_seg;
      end
      ST_DONE:  sort_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latch, current segment, pivot capture, watchdog, err and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ntot_q  <= '0;
      lo_q    <= '0;
      n_q     <= '0;
      p_q     <= '0;
      parts_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          ntot_q  <= n_total;
          err_q   <= 1'b0;
          parts_q <= '0;
        end
        ST_POP: if (!empty) begin
          lo_q <= top.low;
          n_q  <= top.count;
        end
        ST_SETUP: wd_q <= '0;
        ST_RUN: begin
          if (part_done) begin
            p_q     <= part_index;
            parts_q <= parts_q + IW'(1);
            if (idx_bad) err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WDW'(1);
            if (wd_exp) err_q <= 1'b1;
          end
        end
        ST_SPLIT: if (ovf) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign part_low   = lo_q;
  assign part_count = n_q;
  assign err        = err_q;
  assign parts_cnt  = parts_q;

endmodule

// File: tb/tb_quicksort_ctrl.sv
// Bench for quicksort_ctrl with a behavioural partition engine (Lomuto, pivot = last element).
// Expected request order and final array come from a queue-based quicksort model.
// Responder delays are random; each sort is bounded by a cycle budget.
module tb_quicksort_ctrl;
  import qs_pkg::*;

  localparam int M_NORM  = 0;  // real partition
  localparam int M_LO    = 1;  // always answer p = lo, array untouched
  localparam int M_BAD   = 2;  // answer out-of-range index 12
  localparam int M_NEVER = 3;  // never answer

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] n_total;
  logic          mem_load, part_start, part_done, busy, sort_done, err;
  logic [IW-1:0] part_low, part_count, part_index, parts_cnt;

  int checks = 0;
  int errors = 0;

  int arr [K];
  int src [K];
  int mode;
  int exp_lo[$], exp_n[$], req_lo[$], req_n[$];
  int done_cnt, ml_cnt, hi_cnt;
  int pend, wait_c;
  logic          prev_start;
  logic [IW-1:0] prev_low, prev_cnt;

  quicksort_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_total    (n_total),
    .mem_load   (mem_load),
    .part_start (part_start),
    .part_low   (part_low),
    .part_count (part_count),
    .part_done  (part_done),
    .part_index (part_index),
    .busy       (busy),
    .sort_done  (sort_done),
    .err        (err),
    .parts_cnt  (parts_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int do_part(int lo, int n);
    int pv, i, t;
    pv = arr[lo+n-1];
    i  = lo;
    for (int j = lo; j < lo + n - 1; j++) begin
      if (arr[j] < pv) begin
        t = arr[i]; arr[i] = arr[j]; arr[j] = t;
        i++;
      end
    end
    t = arr[i]; arr[i] = arr[lo+n-1]; arr[lo+n-1] = t;
    return i;
  endfunction

  // Behavioural engine and interface monitor, all sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      part_done  = 1'b0;
      part_index = '0;
      pend       = 0;
      prev_start = 1'b0;
    end else begin
      if (mem_load) begin
        ml_cnt++;
        for (int i = 0; i < K; i++) arr[i] = src[i];
      end
      if (sort_done)  done_cnt++;
      if (part_start) hi_cnt++;
      if (part_start && !prev_start) begin
        check("setup_low", part_low, prev_low);
        check("setup_cnt", part_count, prev_cnt);
        req_lo.push_back(int'(part_low));
        req_n.push_back(int'(part_count));
        pend   = 1;
        wait_c = $urandom_range(0, 4);
      end else if (part_start) begin
        check("hold_low", part_low, prev_low);
      end
      if (!part_start) begin
        part_done = 1'b0;
      end else if (pend != 0 && mode != M_NEVER) begin
        if (wait_c > 0) wait_c--;
        else begin
          pend = 0;
          if (mode == M_NORM)    part_index = IW'(do_part(int'(part_low), int'(part_count)));
          else if (mode == M_LO) part_index = part_low;
          else                   part_index = IW'(12);
          part_done = 1'b1;
        end
      end
      prev_start = part_start;
      prev_low   = part_low;
      prev_cnt   = part_count;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_pstart"}, part_start, 0);
    check({tag, "_mload"}, mem_load, 0);
    check({tag, "_done"},  sort_done, 0);
    check({tag, "_err"},   err, 0);
    check({tag, "_parts"}, parts_cnt, 0);
    check({tag, "_plow"},  part_low, 0);
    check({tag, "_pcnt"},  part_count, 0);
  endtask

  // Quicksort over an explicit stack queue: larger half pushed first, ties push right first
  task automatic model_sort(input int n, input int m);
    int s_lo[$], s_n[$];
    int lo, c, p, ln, rn;
    exp_lo.delete(); exp_n.delete();
    for (int i = 0; i < K; i++) arr[i] = src[i];
    if (n >= 2) begin s_lo.push_back(0); s_n.push_back(n); end
    while (s_lo.size() > 0) begin
      lo = s_lo.pop_back();
      c  = s_n.pop_back();
      exp_lo.push_back(lo);
      exp_n.push_back(c);
      if (m == M_BAD || m == M_NEVER) break;
      p  = (m == M_LO) ? lo : do_part(lo, c);
      ln = p - lo;
      rn = lo + c - 1 - p;
      if (rn >= ln) begin
        if (rn >= 2) begin s_lo.push_back(p + 1); s_n.push_back(rn); end
        if (ln >= 2) begin s_lo.push_back(lo);    s_n.push_back(ln); end
      end else begin
        if (ln >= 2) begin s_lo.push_back(lo);    s_n.push_back(ln); end
        if (rn >= 2) begin s_lo.push_back(p + 1); s_n.push_back(rn); end
      end
    end
  endtask

  task automatic run_sort(input int n, input int m, input bit glitch);
    int cyc, ml_cyc, t, exp_err, exp_parts;
    int ref_a [K];
    mode = m;
    for (int i = 0; i < K; i++) ref_a[i] = src[i];
    if (m == M_NORM || m == M_LO) begin
      for (int i = 1; i < n; i++)
        for (int j = i; j > 0 && ref_a[j-1] > ref_a[j]; j--) begin
          t = ref_a[j]; ref_a[j] = ref_a[j-1]; ref_a[j-1] = t;
        end
    end
    model_sort(n, m);
    exp_err   = (m >= M_BAD && n >= 2) ? 1 : 0;
    exp_parts = (m == M_NEVER) ? 0 : exp_lo.size();
    req_lo.delete(); req_n.delete();
    done_cnt = 0; ml_cnt = 0; hi_cnt = 0;
    @(negedge clk);
    start   = 1'b1;
    n_total = IW'(n);
    cyc     = 0;
    ml_cyc  = -1;
    do begin
      @(negedge clk);
      cyc++;
      start = glitch && (cyc == 4);
      if (start) n_total = IW'(3);
      if (cyc == 1) check("err_clear", err, 0);
      if (mem_load && ml_cyc < 0) ml_cyc = cyc;
    end while (!sort_done && cyc < 3000);
    check("done_seen", sort_done, 1);
    check("ml_cyc", ml_cyc, 1);
    if (n < 2) check("done_cyc", cyc, 3);
    check("err", err, exp_err);
    check("parts", parts_cnt, exp_parts);
    @(negedge clk);
    check("busy_off", busy, 0);
    check("done_pulse", sort_done, 0);
    check("done_cnt", done_cnt, 1);
    check("ml_cnt", ml_cnt, 1);
    check("req_num", req_lo.size(), exp_lo.size());
    for (int i = 0; i < exp_lo.size() && i < req_lo.size(); i++) begin
      check("req_lo", req_lo[i], exp_lo[i]);
      check("req_n", req_n[i], exp_n[i]);
    end
    for (int i = 0; i < K; i++) check("array", arr[i], ref_a[i]);
    if (m == M_NEVER) check("tmo_cycles", hi_cnt, TMO);
  endtask

  initial begin
    int cyc, n;
    rst_n = 1'b0; start = 1'b0; n_total = '0; mode = M_NORM;
    done_cnt = 0; ml_cnt = 0; hi_cnt = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // reversed array, full length, with a stray start while busy
    for (int i = 0; i < K; i++) src[i] = K - 1 - i;
    run_sort(K, M_NORM, 1'b1);

    // degenerate lengths
    run_sort(1, M_NORM, 1'b0);
    run_sort(0, M_NORM, 1'b0);

    // already sorted with a worst-case pivot answer
    for (int i = 0; i < K; i++) src[i] = i;
    run_sort(K, M_LO, 1'b0);
    check("lo_parts", parts_cnt, 9);

    // bad pivot index, then a clean sort clears err
    for (int i = 0; i < K; i++) src[i] = $urandom_range(0, 31);
    run_sort(K, M_BAD, 1'b0);
    run_sort(K, M_NORM, 1'b0);

    // engine never answers
    run_sort(6, M_NEVER, 1'b0);

    // random arrays and lengths
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < K; i++) src[i] = $urandom_range(0, 31);
      n = $urandom_range(0, K);
      run_sort(n, M_NORM, r[0]);
    end

    // reset while a partition is running
    mode = M_NORM;
    for (int i = 0; i < K; i++) src[i] = $urandom_range(0, 31);
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; n_total = IW'(K);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!part_start && cyc < 100) begin @(negedge clk); cyc++; end
    check("run_reached", part_start, 1);
    #3 rst_n = 1'b0;
    #1 check_zero("abort");
    @(negedge clk);
    @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < K; i++) src[i] = (i < 5) ? 5 - i : 20 + i;
    run_sort(5, M_NORM, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
